// File: rtl/mp3_pkg.sv
// Shared constants and types for the MP3 frame sequencer.
// Frame-length ROM holds floor(144000*kbps/fs) for MPEG-1 Layer III.
package mp3_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_SYNC2,
        ST_HDR,
        ST_CRC,
        ST_SIDE,
        ST_PRESENT,
        ST_MAIN,
        ST_NEXT
    } state_t;

    localparam logic [7:0]  SYNC_BYTE         = 8'hFF;
    localparam logic [6:0]  SYNC2_PAT         = 7'b1111101;
    localparam logic [10:0] HDR_BYTES         = 11'd4;
    localparam logic [10:0] CRC_BYTES         = 11'd2;
    localparam logic [10:0] SIDE_BYTES_MONO   = 11'd17;
    localparam logic [10:0] SIDE_BYTES_STEREO = 11'd32;

    // [bitrate_idx][fs_idx]; fs_idx 0=44.1k, 1=48k, 2=32k, 3=reserved
    localparam logic [0:15][0:3][10:0] FRAME_LEN_ROM = '{
        '{11'd0,    11'd0,   11'd0,    11'd0},
        '{11'd104,  11'd96,  11'd144,  11'd0},
        '{11'd130,  11'd120, 11'd180,  11'd0},
        '{11'd156,  11'd144, 11'd216,  11'd0},
        '{11'd182,  11'd168, 11'd252,  11'd0},
        '{11'd208,  11'd192, 11'd288,  11'd0},
        '{11'd261,  11'd240, 11'd360,  11'd0},
        '{11'd313,  11'd288, 11'd432,  11'd0},
        '{11'd365,  11'd336, 11'd504,  11'd0},
        '{11'd417,  11'd384, 11'd576,  11'd0},
        '{11'd522,  11'd480, 11'd720,  11'd0},
        '{11'd626,  11'd576, 11'd864,  11'd0},
        '{11'd731,  11'd672, 11'd1008, 11'd0},
        '{11'd835,  11'd768, 11'd1152, 11'd0},
        '{11'd1044, 11'd960, 11'd1440, 11'd0},
        '{11'd0,    11'd0,   11'd0,    11'd0}
    };

endpackage

// File: rtl/mp3_frame_len.sv
// Frame length lookup: ROM entry plus one padding byte.
// Purely combinational; invalid indices read as 0 (+pad).
module mp3_frame_len
    import mp3_pkg::*;
(
    input  logic [3:0]  bitrate_idx_i,
    input  logic [1:0]  fs_idx_i,
    input  logic        pad_i,
    output logic [10:0] frame_len_o
);

    // ROM read and padding add
    always_comb begin
        frame_len_o = FRAME_LEN_ROM[bitrate_idx_i][fs_idx_i] + {10'd0, pad_i};
    end

endmodule

// File: rtl/mp3_frame_sequencer.sv
// MPEG-1 Layer III frame sequencer: sync hunt, header/side-info
// capture, held info bundle, then zero-latency main-data forwarding.
module mp3_frame_sequencer
    import mp3_pkg::*;
(
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid_in,
    output logic         byte_ready_out,
    output logic [31:0]  header_out,
    output logic [255:0] side_info_out,
    output logic [10:0]  frame_len_out,
    output logic         info_valid_out,
    input  logic         info_ready_in,
    output logic [7:0]   main_byte_out,
    output logic         main_valid_out,
    input  logic         main_ready_in,
    output logic         sync_lost_out
);

    state_t         state_q;
    logic [10:0]    cnt_q;
    logic [31:0]    header_q;
    logic [255:0]   side_q;
    logic [10:0]    frame_len_q;
    logic           info_valid_q;
    logic           sync_lost_q;

    logic           fire;
    logic           hdr_bad;
    logic [10:0]    len_lookup;
    logic [10:0]    side_len;
    logic [10:0]    main_len;
    logic [7:0]     side_lsb;

    mp3_frame_len u_len (
        .bitrate_idx_i (header_q[15:12]),
        .fs_idx_i      (header_q[11:10]),
        .pad_i         (header_q[9]),
        .frame_len_o   (len_lookup)
    );

    assign fire     = byte_valid_in & byte_ready_out;
    assign hdr_bad  = (header_q[15:12] == 4'h0) |
                      (header_q[15:12] == 4'hF) |
                      (header_q[11:10] == 2'b11);
    assign side_len = (header_q[7:6] == 2'b11) ? SIDE_BYTES_MONO
                                               : SIDE_BYTES_STEREO;
    assign main_len = frame_len_q - HDR_BYTES
                    - (header_q[16] ? 11'd0 : CRC_BYTES) - side_len;
    // side byte k lands at bit (31-k)*8, i.e. left-justified
    assign side_lsb = {~cnt_q[4:0], 3'b000};

    assign header_out     = header_q;
    assign side_info_out  = side_q;
    assign frame_len_out  = frame_len_q;
    assign info_valid_out = info_valid_q;
    assign sync_lost_out  = sync_lost_q;
    assign main_byte_out  = (state_q == ST_MAIN) ? byte_in : 8'h00;
    assign main_valid_out = (state_q == ST_MAIN) & byte_valid_in;

    // Input ready: stall while presenting, pass through downstream in MAIN
    always_comb begin
        byte_ready_out = 1'b1;
        unique case (state_q)
            ST_PRESENT: byte_ready_out = 1'b0;
            ST_MAIN:    byte_ready_out = main_ready_in;
            default:    byte_ready_out = 1'b1;
        endcase
    end

    // Frame FSM with byte counter and capture registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_HUNT;
            cnt_q        <= '0;
            header_q     <= '0;
            side_q       <= '0;
            frame_len_q  <= '0;
            info_valid_q <= 1'b0;
            sync_lost_q  <= 1'b0;
        end else begin
            sync_lost_q <= 1'b0;
            unique case (state_q)
                ST_HUNT: begin
                    if (fire && byte_in == SYNC_BYTE) begin
                        state_q <= ST_SYNC2;
                        cnt_q   <= '0;
                    end
                end
                ST_SYNC2: begin
                    if (fire) begin
                        if (byte_in[7:1] == SYNC2_PAT) begin
                            header_q <= {SYNC_BYTE, byte_in, 16'h0000};
                            state_q  <= ST_HDR;
                            cnt_q    <= '0;
                        end else if (byte_in != SYNC_BYTE) begin
                            state_q <= ST_HUNT;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_HDR: begin
                    if (fire) begin
                        if (cnt_q == 11'd0) begin
                            header_q[15:8] <= byte_in;
                            cnt_q          <= cnt_q + 11'd1;
                        end else begin
                            header_q[7:0] <= byte_in;
                            cnt_q         <= '0;
                            if (hdr_bad) begin
                                state_q     <= ST_HUNT;
                                sync_lost_q <= 1'b1;
                            end else begin
                                frame_len_q <= len_lookup;
                                side_q      <= '0;
                                state_q     <= header_q[16] ? ST_SIDE : ST_CRC;
                            end
                        end
                    end
                end
                ST_CRC: begin
                    if (fire) begin
                        if (cnt_q == CRC_BYTES - 11'd1) begin
                            state_q <= ST_SIDE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 11'd1;
                        end
                    end
                end
                ST_SIDE: begin
                    if (fire) begin
                        side_q[side_lsb +: 8] <= byte_in;
                        if (cnt_q == side_len - 11'd1) begin
                            state_q      <= ST_PRESENT;
                            info_valid_q <= 1'b1;
                            cnt_q        <= '0;
                        end else begin
                            cnt_q <= cnt_q + 11'd1;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (info_ready_in) begin
                        state_q      <= ST_MAIN;
                        info_valid_q <= 1'b0;
                        cnt_q        <= '0;
                    end
                end
                ST_MAIN: begin
                    if (fire) begin
                        if (cnt_q == main_len - 11'd1) begin
                            state_q <= ST_NEXT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 11'd1;
                        end
                    end
                end
                ST_NEXT: begin
                    if (fire) begin
                        cnt_q <= '0;
                        if (byte_in == SYNC_BYTE) begin
                            state_q <= ST_SYNC2;
                        end else begin
                            state_q     <= ST_HUNT;
                            sync_lost_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp3_frame_sequencer.sv
// Scoreboard bench for mp3_frame_sequencer: directed frames,
// backpressure, bad header, lost sync and mid-frame reset.
module tb_mp3_frame_sequencer;

    typedef struct {
        logic [31:0]  hdr;
        logic [10:0]  len;
        logic [255:0] side;
    } info_t;

    logic         clk = 1'b0;
    logic         rst_in;
    logic [7:0]   byte_in;
    logic         byte_valid_in;
    logic         byte_ready_out;
    logic [31:0]  header_out;
    logic [255:0] side_info_out;
    logic [10:0]  frame_len_out;
    logic         info_valid_out;
    logic         info_ready_in;
    logic [7:0]   main_byte_out;
    logic         main_valid_out;
    logic         main_ready_in;
    logic         sync_lost_out;

    int checks = 0;
    int errors = 0;
    int sync_cnt = 0;
    int main_rx = 0;
    bit rnd = 0;
    bit prev_iv = 0;

    logic [7:0] exp_main[$];
    info_t      exp_info[$];

    mp3_frame_sequencer dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .byte_ready_out (byte_ready_out),
        .header_out     (header_out),
        .side_info_out  (side_info_out),
        .frame_len_out  (frame_len_out),
        .info_valid_out (info_valid_out),
        .info_ready_in  (info_ready_in),
        .main_byte_out  (main_byte_out),
        .main_valid_out (main_valid_out),
        .main_ready_in  (main_ready_in),
        .sync_lost_out  (sync_lost_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // main-data monitor
    always @(negedge clk) begin
        if (!rst_in && main_valid_out && main_ready_in) begin
            if (exp_main.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_extra got %h want none", main_byte_out);
            end else begin
                check("main_byte", 256'(main_byte_out), 256'(exp_main.pop_front()));
                main_rx++;
            end
        end
    end

    // info bundle monitor, compares at rising info_valid_out
    always @(negedge clk) begin
        if (!rst_in && info_valid_out && !prev_iv) begin
            if (exp_info.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL info_extra got %h want none", header_out);
            end else begin
                info_t e;
                e = exp_info.pop_front();
                check("header", 256'(header_out), 256'(e.hdr));
                check("frame_len", 256'(frame_len_out), 256'(e.len));
                check("side_info", side_info_out, e.side);
            end
        end
        prev_iv = info_valid_out;
    end

    // sync-lost pulse counter (one count per high cycle)
    always @(negedge clk) begin
        if (!rst_in && sync_lost_out) sync_cnt++;
    end

    // downstream ready, randomized on demand
    always @(posedge clk) begin
        #1;
        main_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        if (rnd && $urandom_range(0, 2) == 0) begin
            byte_valid_in = 1'b0;
            @(posedge clk);
            #1;
        end
        byte_in = b;
        byte_valid_in = 1'b1;
        forever begin
            @(negedge clk);
            if (byte_ready_out) break;
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got stalled want ready");
                break;
            end
        end
        @(posedge clk);
        #1;
        byte_valid_in = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input bit lead_ff,
                              input bit crc, input int nside,
                              input int nmain, input logic [10:0] flen,
                              input logic [7:0] seed, input bit hold);
        info_t e;
        logic [7:0] b;
        e.hdr = hdr;
        e.len = flen;
        e.side = '0;
        if (lead_ff) send(hdr[31:24]);
        send(hdr[23:16]);
        send(hdr[15:8]);
        send(hdr[7:0]);
        if (crc) begin
            send(8'hC3);
            send(8'h3C);
        end
        for (int i = 0; i < nside; i++) begin
            b = seed + 8'(i * 5);
            e.side[255 - 8 * i -: 8] = b;
        end
        exp_info.push_back(e);
        for (int i = 0; i < nside; i++) send(seed + 8'(i * 5));
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("hold_ready", 256'(byte_ready_out), 256'(0));
                check("hold_valid", 256'(info_valid_out), 256'(1));
                check("hold_hdr", 256'(header_out), 256'(hdr));
                check("hold_len", 256'(frame_len_out), 256'(flen));
                check("hold_side", side_info_out, e.side);
            end
            @(posedge clk);
            #1;
            info_ready_in = 1'b1;
        end
        for (int i = 0; i < nmain; i++) begin
            b = 8'(i * 3) ^ seed;
            exp_main.push_back(b);
            send(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hdr"}, 256'(header_out), 256'(0));
        check({tag, "_side"}, side_info_out, 256'(0));
        check({tag, "_len"}, 256'(frame_len_out), 256'(0));
        check({tag, "_ivalid"}, 256'(info_valid_out), 256'(0));
        check({tag, "_mvalid"}, 256'(main_valid_out), 256'(0));
        check({tag, "_mbyte"}, 256'(main_byte_out), 256'(0));
        check({tag, "_slost"}, 256'(sync_lost_out), 256'(0));
        check({tag, "_ready"}, 256'(byte_ready_out), 256'(1));
    endtask

    initial begin
        rst_in = 1'b1;
        byte_in = 8'h00;
        byte_valid_in = 1'b0;
        info_ready_in = 1'b1;
        main_ready_in = 1'b1;
        idle(3);
        check_reset_outputs("reset");
        rst_in = 1'b0;
        idle(2);

        // mono frame, no CRC; trailing FF leaves us in SYNC2
        send_frame(32'hFFFB90C0, 1, 0, 17, 396, 11'd417, 8'h11, 0);
        send(8'hFF);

        // stereo, CRC, padding; continues from SYNC2
        send_frame(32'hFFFA9200, 0, 1, 32, 380, 11'd418, 8'h5A, 0);
        send(8'h00);
        idle(3);
        check("sync_lost_boundary", 256'(sync_cnt), 256'(1));

        // garbage before sync, held info, random backpressure on main
        send(8'h00);
        send(8'h12);
        send(8'hFF);
        info_ready_in = 1'b0;
        rnd = 1'b0;
        fork
            begin
                @(posedge info_ready_in);
                rnd = 1'b1;
            end
        join_none
        send_frame(32'hFFFB90C0, 1, 0, 17, 396, 11'd417, 8'hA7, 1);
        rnd = 1'b0;
        idle(2);
        send(8'hFF);
        send(8'h55);

        // bad bitrate index
        send(8'hFF);
        send(8'hFB);
        send(8'hF0);
        send(8'h00);
        idle(3);
        check("sync_lost_badhdr", 256'(sync_cnt), 256'(2));
        check("no_info_badhdr", 256'(info_valid_out), 256'(0));

        // reset mid-SIDE
        send(8'hFF);
        send(8'hFB);
        send(8'h90);
        send(8'hC0);
        for (int i = 0; i < 5; i++) send(8'h77);
        rst_in = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        idle(2);

        send_frame(32'hFFFB90C0, 1, 0, 17, 396, 11'd417, 8'h3C, 0);
        send(8'hFF);
        idle(5);

        check("main_leftover", 256'(exp_main.size()), 256'(0));
        check("info_leftover", 256'(exp_info.size()), 256'(0));
        check("main_total", 256'(main_rx), 256'(396 + 380 + 396 + 396));
        check("sync_lost_total", 256'(sync_cnt), 256'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp3_frame_sequencer.md
# mp3_frame_sequencer

Byte-stream front end for the MP3 decoder. It hunts for MPEG-1 Layer III frame sync and captures the 4-byte header. It skips the optional CRC and captures the 17- or 32-byte side info, then presents header and side info to the header/side-info parser as one held bundle. After that it forwards the frame's main-data bytes downstream and re-checks sync at the start of the next frame.

## Interface
Parameters:
- none; all frame constants are in `mp3_pkg`.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- byte_in  input  8  incoming bitstream byte.
- byte_valid_in  input  1  byte_in valid.
- byte_ready_out  output  1  block accepts byte_in; a byte transfers when valid and ready are both high.
- header_out  output  32  captured header; first byte in [31:24].
- side_info_out  output  256  side info, left-justified; first byte in [255:248]; unused low bits are 0.
- frame_len_out  output  11  total frame length in bytes, including padding.
- info_valid_out  output  1  header_out, side_info_out and frame_len_out are valid.
- info_ready_in  input  1  parser has accepted the bundle.
- main_byte_out  output  8  main-data byte.
- main_valid_out  output  1  main_byte_out valid.
- main_ready_in  input  1  downstream accepts a main-data byte.
- sync_lost_out  output  1  one-cycle pulse when a sync or header check fails.

## Operation
- States: HUNT, SYNC2, HDR, CRC, SIDE, PRESENT, MAIN, NEXT.
- HUNT: accept bytes; 0xFF -> SYNC2; any other byte stays in HUNT.
- SYNC2: a byte with [7:1]=7'b1111101 (sync, MPEG-1, Layer III) -> HDR.
  - 0xFF stays in SYNC2.
  - Any other byte -> HUNT.
- HDR: accept header bytes 3 and 4.
  - Invalid fields -> HUNT with a sync_lost_out pulse. Invalid means bitrate index header[15:12] is 0000 or 1111, or sample-rate index header[11:10] is 11.
  - Otherwise, if header[16]=0 -> CRC; else -> SIDE.
- CRC: accept and discard 2 bytes -> SIDE.
- SIDE: accept 17 bytes if header[7:6]=11 (mono), else 32 bytes; shift into side_info_out from the MSB down -> PRESENT.
- PRESENT: byte_ready_out=0 and info_valid_out=1; all info outputs are held stable. The cycle info_ready_in=1 -> MAIN.
- MAIN: pass-through path.
  - main_byte_out=byte_in, main_valid_out=byte_valid_in, byte_ready_out=main_ready_in.
  - Count main bytes = frame_len - 4 - (2 if CRC) - side_bytes.
  - After the last byte transfers -> NEXT.
- NEXT: expect 0xFF.
  - 0xFF -> SYNC2.
  - Any other byte -> sync_lost_out pulse, then HUNT (that byte is consumed).
- frame_len = FRAME_LEN_ROM[bitrate_idx][fs_idx] + header[9].
  - ROM entry = floor(144000*kbps/fs_hz); e.g. 128 kbps at 44.1 kHz = 417, at 48 kHz = 384.
- Byte counter: 11 bits, cleared on every state entry.
- byte_ready_out is 1 in HUNT, SYNC2, HDR, CRC, SIDE and NEXT; 0 in PRESENT; main_ready_in in MAIN.

## Timing
- Reset: state HUNT; header_out, side_info_out, frame_len_out, info_valid_out, main_valid_out and sync_lost_out are 0.
  - main_byte_out is 0 outside MAIN.
  - byte_ready_out is 1 (HUNT); reset is asynchronous and can occur in any state, including mid-SIDE or mid-MAIN.
- At most one byte per cycle in every state.
- info_valid_out rises the cycle after the last side-info byte transfers. It falls the cycle after info_ready_in is sampled high.
- frame_len_out is registered the cycle after header byte 4 transfers and holds until the next header capture.
- MAIN path is combinational, zero latency; no byte is dropped or duplicated under any valid/ready pattern.
- sync_lost_out is asserted the cycle after the offending byte transfers, for exactly 1 cycle.
- byte_valid_in=0 stalls every state without changing its count.

## Structure
- `mp3_pkg` holds:
  - state enum;
  - SYNC constants;
  - SIDE_BYTES_MONO=17, SIDE_BYTES_STEREO=32;
  - FRAME_LEN_ROM (16x4 of 11-bit; invalid entries 0).
- One sub-module, `mp3_frame_len`: combinational ROM lookup plus padding add.
- FSM, counter and capture registers live in the top module.

## Test plan
1. Mono frame, stimulus FF FB 90 C0, 17 side bytes, then 396 main bytes, then FF:
   - header_out=0xFFFB90C0, frame_len_out=417;
   - side_info_out[119:0]=0;
   - 396 main bytes out in order; state then SYNC2.
2. Stereo frame with CRC and padding, stimulus FF FA 92 00, 2 CRC bytes, 32 side bytes, 380 main bytes:
   - frame_len_out=418; CRC bytes absent from both outputs;
   - exactly 380 main bytes out.
3. Garbage before sync, stimulus 00 12 FF FF FB 90 C0 ...:
   - lock occurs on the second FF; the frame decodes as in test 1.
4. Bad header, stimulus FF FB F0 00:
   - sync_lost_out pulses once; no info_valid_out; state returns to HUNT.
5. Backpressure:
   - info_ready_in held low for 10 cycles -> byte_ready_out=0 and outputs stable throughout.
   - Random main_ready_in and byte_valid_in during MAIN -> output byte sequence equals input sequence.
6. Lost sync and reset:
   - 0x00 at a frame boundary -> sync_lost_out pulse, then HUNT.
   - rst_in asserted mid-SIDE -> all outputs at reset values; a clean frame afterwards decodes correctly.
